// File: rtl/fb_bank_arbiter.sv
// Double-buffered framebuffer arbiter: display reads one BRAM bank while the
// sensor writer fills the other; banks swap on vsync after a completed frame.
module fb_bank_arbiter #(
    parameter int p_addr_width    = 10,
    parameter int p_data_width    = 16,
    parameter int p_frame_words   = 768,
    parameter int p_wr_starve_max = 8
) (
    input  logic                    i_clk_pixel,
    input  logic                    i_rst_n,
    input  logic                    i_vsync,
    input  logic                    i_rd_req,
    input  logic [p_addr_width-1:0] i_rd_addr,
    output logic                    o_rd_ack,
    output logic                    o_rd_valid,
    output logic [p_data_width-1:0] o_rd_data,
    input  logic                    i_wr_req,
    input  logic [p_addr_width-1:0] i_wr_addr,
    input  logic [p_data_width-1:0] i_wr_data,
    output logic                    o_wr_ack,
    input  logic                    i_wr_frame_done,
    output logic                    o_ram_en,
    output logic                    o_ram_we,
    output logic [p_addr_width:0]   o_ram_addr,
    output logic [p_data_width-1:0] o_ram_wdata,
    input  logic [p_data_width-1:0] i_ram_rdata,
    output logic                    o_disp_bank,
    output logic                    o_frame_drop
);

    localparam logic ST_FILL = 1'b0;
    localparam logic ST_PEND = 1'b1;

    localparam int CW = $clog2(p_wr_starve_max + 1);
    localparam logic [CW-1:0] STARVE_MAX = CW'(p_wr_starve_max);
    localparam logic [p_addr_width:0] FRAME_WORDS = (p_addr_width + 1)'(p_frame_words);

    logic                    state_q, state_d;
    logic                    disp_bank_q, disp_bank_d;
    logic                    vsync_q, vsync_d;
    logic [CW-1:0]           starve_cnt_q, starve_cnt_d;
    logic                    frame_drop_q, frame_drop_d;
    logic                    ram_en_q, ram_en_d;
    logic                    ram_we_q, ram_we_d;
    logic [p_addr_width:0]   ram_addr_q, ram_addr_d;
    logic [p_data_width-1:0] ram_wdata_q, ram_wdata_d;
    logic                    rd_v1_q, rd_v1_d;
    logic                    rd_v2_q, rd_v2_d;
    logic                    rd_oor1_q, rd_oor1_d;
    logic                    rd_oor2_q, rd_oor2_d;

    logic vsync_rise;
    logic wr_force;
    logic wr_grant;
    logic rd_grant;
    logic rd_in_range;
    logic wr_in_range;

    // Grants are gated by reset so the combinational acks also read 0 in reset.
    always_comb begin
        vsync_rise  = i_vsync & ~vsync_q;
        wr_force    = (starve_cnt_q == STARVE_MAX);
        wr_grant    = i_rst_n && i_wr_req && (state_q == ST_FILL) && (!i_rd_req || wr_force);
        rd_grant    = i_rst_n && i_rd_req && !wr_grant;
        rd_in_range = ({1'b0, i_rd_addr} < FRAME_WORDS);
        wr_in_range = ({1'b0, i_wr_addr} < FRAME_WORDS);
    end

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!i_wr_req || wr_grant) begin
            starve_cnt_d = '0;
        end else if (state_q == ST_FILL && starve_cnt_q != STARVE_MAX) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    always_comb begin
        ram_en_d    = 1'b0;
        ram_we_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        if (wr_grant) begin
            ram_addr_d  = {~disp_bank_q, i_wr_addr};
            ram_wdata_d = i_wr_data;
            ram_en_d    = wr_in_range;
            ram_we_d    = wr_in_range;
        end else if (rd_grant) begin
            ram_addr_d = {disp_bank_q, i_rd_addr};
            ram_en_d   = rd_in_range;
        end
    end

    // Out-of-range reads travel down the pipe too so they still return a zero word.
    always_comb begin
        rd_v1_d   = rd_grant;
        rd_oor1_d = rd_grant && !rd_in_range;
        rd_v2_d   = rd_v1_q;
        rd_oor2_d = rd_oor1_q;
    end

    always_comb begin
        state_d      = state_q;
        disp_bank_d  = disp_bank_q;
        frame_drop_d = 1'b0;
        vsync_d      = i_vsync;
        case (state_q)
            ST_FILL: begin
                if (i_wr_frame_done) begin
                    state_d = ST_PEND;
                end
            end
            ST_PEND: begin
                if (vsync_rise) begin
                    disp_bank_d = ~disp_bank_q;
                    state_d     = ST_FILL;
                end
                if (i_wr_frame_done) begin
                    frame_drop_d = 1'b1;
                end
            end
            default: state_d = ST_FILL;
        endcase
    end

    always_ff @(posedge i_clk_pixel or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= ST_FILL;
            disp_bank_q  <= 1'b0;
            vsync_q      <= 1'b0;
            starve_cnt_q <= '0;
            frame_drop_q <= 1'b0;
            ram_en_q     <= 1'b0;
            ram_we_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
            rd_v1_q      <= 1'b0;
            rd_v2_q      <= 1'b0;
            rd_oor1_q    <= 1'b0;
            rd_oor2_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            disp_bank_q  <= disp_bank_d;
            vsync_q      <= vsync_d;
            starve_cnt_q <= starve_cnt_d;
            frame_drop_q <= frame_drop_d;
            ram_en_q     <= ram_en_d;
            ram_we_q     <= ram_we_d;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
            rd_v1_q      <= rd_v1_d;
            rd_v2_q      <= rd_v2_d;
            rd_oor1_q    <= rd_oor1_d;
            rd_oor2_q    <= rd_oor2_d;
        end
    end

    assign o_rd_ack     = rd_grant;
    assign o_wr_ack     = wr_grant;
    assign o_rd_valid   = rd_v2_q;
    assign o_rd_data    = (rd_v2_q && !rd_oor2_q) ? i_ram_rdata : '0;
    assign o_ram_en     = ram_en_q;
    assign o_ram_we     = ram_we_q;
    assign o_ram_addr   = ram_addr_q;
    assign o_ram_wdata  = ram_wdata_q;
    assign o_disp_bank  = disp_bank_q;
    assign o_frame_drop = frame_drop_q;

endmodule

// File: tb/tb_fb_bank_arbiter.sv
// Directed bench for fb_bank_arbiter with a registered-output BRAM model and
// hand-computed expectations for latency, priority, swap and reset behaviour.
module tb_fb_bank_arbiter;

    logic        clk;
    logic        rst_n;
    logic        vsync;
    logic        rd_req;
    logic [9:0]  rd_addr;
    logic        rd_ack;
    logic        rd_valid;
    logic [15:0] rd_data;
    logic        wr_req;
    logic [9:0]  wr_addr;
    logic [15:0] wr_data;
    logic        wr_ack;
    logic        frame_done;
    logic        ram_en;
    logic        ram_we;
    logic [10:0] ram_addr;
    logic [15:0] ram_wdata;
    logic [15:0] ram_rdata;
    logic        disp_bank;
    logic        frame_drop;

    logic        preload_en;
    logic [10:0] preload_addr;
    logic [15:0] preload_data;
    logic [15:0] mem [0:2047];

    int compared;
    int mismatched;
    int ack_count;

    fb_bank_arbiter dut (
        .i_clk_pixel     (clk),
        .i_rst_n         (rst_n),
        .i_vsync         (vsync),
        .i_rd_req        (rd_req),
        .i_rd_addr       (rd_addr),
        .o_rd_ack        (rd_ack),
        .o_rd_valid      (rd_valid),
        .o_rd_data       (rd_data),
        .i_wr_req        (wr_req),
        .i_wr_addr       (wr_addr),
        .i_wr_data       (wr_data),
        .o_wr_ack        (wr_ack),
        .i_wr_frame_done (frame_done),
        .o_ram_en        (ram_en),
        .o_ram_we        (ram_we),
        .o_ram_addr      (ram_addr),
        .o_ram_wdata     (ram_wdata),
        .i_ram_rdata     (ram_rdata),
        .o_disp_bank     (disp_bank),
        .o_frame_drop    (frame_drop)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single-port BRAM with registered read data; preload port lets the bench seed words.
    always @(posedge clk) begin
        if (preload_en) begin
            mem[preload_addr] <= preload_data;
        end else if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata     <= mem[ram_addr];
        end
    end

    // Drives one cycle of inputs just after the falling edge, then lets combinational outputs settle.
    task automatic applyStimulus(input logic rr, input logic [9:0] ra,
                                 input logic wr, input logic [9:0] wa, input logic [15:0] wd,
                                 input logic vs, input logic fd);
        @(negedge clk);
        rd_req     = rr;
        rd_addr    = ra;
        wr_req     = wr;
        wr_addr    = wa;
        wr_data    = wd;
        vsync      = vs;
        frame_done = fd;
        #1;
    endtask

    task automatic idle(input logic vs);
        applyStimulus(1'b0, 10'd0, 1'b0, 10'd0, 16'h0, vs, 1'b0);
    endtask

    // Every comparison in the bench goes through here.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    initial begin
        compared     = 0;
        mismatched   = 0;
        rst_n        = 1'b0;
        vsync        = 1'b0;
        rd_req       = 1'b0;
        rd_addr      = '0;
        wr_req       = 1'b0;
        wr_addr      = '0;
        wr_data      = '0;
        frame_done   = 1'b0;
        ram_rdata    = '0;
        preload_en   = 1'b1;
        preload_addr = 11'h005;
        preload_data = 16'hBEEF;

        // Reset state
        @(negedge clk);
        #1;
        checkOutput("rst_ram_en",     {31'b0, ram_en},     32'd0);
        checkOutput("rst_rd_valid",   {31'b0, rd_valid},   32'd0);
        checkOutput("rst_disp_bank",  {31'b0, disp_bank},  32'd0);
        checkOutput("rst_frame_drop", {31'b0, frame_drop}, 32'd0);
        checkOutput("rst_ram_addr",   {21'b0, ram_addr},   32'd0);
        @(negedge clk);
        preload_en = 1'b0;
        rst_n      = 1'b1;

        // Read latency: ack at N, RAM address at N+1, data at N+2
        applyStimulus(1'b1, 10'd5, 1'b0, 10'd0, 16'h0, 1'b0, 1'b0);
        checkOutput("rd_ack_n", {31'b0, rd_ack}, 32'd1);
        idle(1'b0);
        checkOutput("rd_ram_en_n1",   {31'b0, ram_en},   32'd1);
        checkOutput("rd_ram_we_n1",   {31'b0, ram_we},   32'd0);
        checkOutput("rd_ram_addr_n1", {21'b0, ram_addr}, 32'h005);
        checkOutput("rd_valid_n1",    {31'b0, rd_valid}, 32'd0);
        idle(1'b0);
        checkOutput("rd_valid_n2", {31'b0, rd_valid}, 32'd1);
        checkOutput("rd_data_n2",  {16'b0, rd_data},  32'hBEEF);

        // Out-of-range read still acked, no RAM access, zero data
        applyStimulus(1'b1, 10'd800, 1'b0, 10'd0, 16'h0, 1'b0, 1'b0);
        checkOutput("oor_ack", {31'b0, rd_ack}, 32'd1);
        idle(1'b0);
        checkOutput("oor_ram_en", {31'b0, ram_en}, 32'd0);
        idle(1'b0);
        checkOutput("oor_valid", {31'b0, rd_valid}, 32'd1);
        checkOutput("oor_data",  {16'b0, rd_data},  32'h0000);

        // Write goes to the back bank (bank 1 while display shows bank 0)
        applyStimulus(1'b0, 10'd0, 1'b1, 10'd3, 16'h1234, 1'b0, 1'b0);
        checkOutput("wr_ack", {31'b0, wr_ack}, 32'd1);
        idle(1'b0);
        checkOutput("wr_ram_en",    {31'b0, ram_en},    32'd1);
        checkOutput("wr_ram_we",    {31'b0, ram_we},    32'd1);
        checkOutput("wr_ram_addr",  {21'b0, ram_addr},  32'h403);
        checkOutput("wr_ram_wdata", {16'b0, ram_wdata}, 32'h1234);

        // Starvation: with both held, write wins every ninth cycle
        for (int i = 0; i < 27; i++) begin
            applyStimulus(1'b1, 10'd0, 1'b1, 10'd10, 16'(i), 1'b0, 1'b0);
            checkOutput($sformatf("starve_wr_ack_%0d", i), {31'b0, wr_ack}, {31'b0, (i % 9) == 8});
            checkOutput($sformatf("starve_rd_ack_%0d", i), {31'b0, rd_ack}, {31'b0, (i % 9) != 8});
        end
        repeat (3) idle(1'b0);

        // Frame done moves to PEND; writes stall there without vsync
        applyStimulus(1'b0, 10'd0, 1'b0, 10'd0, 16'h0, 1'b0, 1'b1);
        ack_count = 0;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, 10'd0, 1'b1, 10'd7, 16'h5555, 1'b0, 1'b0);
            if (wr_ack) ack_count++;
        end
        checkOutput("pend_wr_acks", ack_count, 32'd0);
        checkOutput("pend_bank",    {31'b0, disp_bank}, 32'd0);

        // A second frame done while pending is dropped with a one-cycle pulse
        applyStimulus(1'b0, 10'd0, 1'b0, 10'd0, 16'h0, 1'b0, 1'b1);
        checkOutput("drop_same_cycle", {31'b0, frame_drop}, 32'd0);
        idle(1'b0);
        checkOutput("drop_pulse", {31'b0, frame_drop}, 32'd1);
        idle(1'b0);
        checkOutput("drop_clear", {31'b0, frame_drop}, 32'd0);

        // Vsync rise swaps banks from the following cycle
        idle(1'b1);
        checkOutput("swap_cycle_bank", {31'b0, disp_bank}, 32'd0);
        applyStimulus(1'b1, 10'd3, 1'b0, 10'd0, 16'h0, 1'b1, 1'b0);
        checkOutput("swap_bank", {31'b0, disp_bank}, 32'd1);
        checkOutput("swap_rd_ack", {31'b0, rd_ack}, 32'd1);
        idle(1'b0);
        checkOutput("swap_ram_addr", {21'b0, ram_addr}, 32'h403);
        idle(1'b0);
        checkOutput("swap_valid", {31'b0, rd_valid}, 32'd1);
        checkOutput("swap_data",  {16'b0, rd_data},  32'h1234);

        // Frame done coincident with vsync rise: no swap until the next rise
        applyStimulus(1'b0, 10'd0, 1'b0, 10'd0, 16'h0, 1'b1, 1'b1);
        applyStimulus(1'b0, 10'd0, 1'b1, 10'd1, 16'h0101, 1'b1, 1'b0);
        checkOutput("corner_no_swap", {31'b0, disp_bank}, 32'd1);
        checkOutput("corner_pend_wr", {31'b0, wr_ack},    32'd0);
        applyStimulus(1'b0, 10'd0, 1'b0, 10'd0, 16'h0, 1'b0, 1'b0);
        applyStimulus(1'b0, 10'd0, 1'b0, 10'd0, 16'h0, 1'b1, 1'b0);
        checkOutput("corner_rise_cycle", {31'b0, disp_bank}, 32'd1);
        applyStimulus(1'b0, 10'd0, 1'b1, 10'd1, 16'h0101, 1'b1, 1'b0);
        checkOutput("corner_swapped", {31'b0, disp_bank}, 32'd0);
        checkOutput("corner_fill_wr", {31'b0, wr_ack},    32'd1);
        idle(1'b0);

        // Reset with a read in flight: everything clears and no valid follows
        applyStimulus(1'b1, 10'd5, 1'b0, 10'd0, 16'h0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_ram_en",    {31'b0, ram_en},    32'd0);
        checkOutput("midrst_rd_ack",    {31'b0, rd_ack},    32'd0);
        checkOutput("midrst_disp_bank", {31'b0, disp_bank}, 32'd0);
        checkOutput("midrst_rd_valid",  {31'b0, rd_valid},  32'd0);
        rd_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        ack_count = 0;
        for (int i = 0; i < 4; i++) begin
            idle(1'b0);
            if (rd_valid) ack_count++;
        end
        checkOutput("midrst_no_valid", ack_count, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
